// File: rtl/gpr_pkg.sv
// Shared constants, types and helpers for the general-purpose register file.
//   GprDataW / GprNumRegs : default register width and register count
//   gpr_data_t / gpr_addr_t : default-sized data and index types
//   is_zero_reg()          : true when an index hits the hardwired zero register
package gpr_pkg;

  localparam int unsigned GprDataW   = 8;
  localparam int unsigned GprNumRegs = 8;
  localparam int unsigned GprAddrW   = $clog2(GprNumRegs);

  typedef logic [GprDataW-1:0] gpr_data_t;
  typedef logic [GprAddrW-1:0] gpr_addr_t;

  // Register 0 is only special when the zero-register option is enabled.
  function automatic logic is_zero_reg(input logic zero_reg_en, input int unsigned addr);
    return zero_reg_en && (addr == 0);
  endfunction

endpackage

// File: rtl/gpr_file_if.sv
// Decode / write-back bus of the register file.
//   master : request side (decode + ALU write-back), drives reads, writes, reserves
//   slave  : register file, returns read data/valid/busy and the pending vector
interface gpr_file_if
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W   = GprDataW,
  parameter int unsigned NUM_REGS = GprNumRegs
);
  localparam int unsigned ADDR_W = $clog2(NUM_REGS);

  logic              rd_en_a;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [DATA_W-1:0] rd_data_a;
  logic              rd_valid_a;
  logic              rd_busy_a;

  logic              rd_en_b;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [DATA_W-1:0] rd_data_b;
  logic              rd_valid_b;
  logic              rd_busy_b;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;

  logic [NUM_REGS-1:0] pending;

  modport master (
    output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    output wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    input  rd_data_a, rd_valid_a, rd_busy_a,
    input  rd_data_b, rd_valid_b, rd_busy_b, pending
  );

  modport slave (
    input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
    input  wr_en, wr_addr, wr_data, rsv_en, rsv_addr,
    output rd_data_a, rd_valid_a, rd_busy_a,
    output rd_data_b, rd_valid_b, rd_busy_b, pending
  );

endinterface

// File: rtl/gpr_read_port.sv
// One registered read port of the register file.
//   clk, rst        : clock, async active-high reset
//   rd_en_i/addr_i  : read request
//   reg_data_i      : current stored value at rd_addr_i
//   reg_pending_i   : current scoreboard bit at rd_addr_i
//   wr_*_i          : same-cycle write, used for forwarding
//   rd_data_o/valid_o/busy_o : registered response, one cycle after the request
module gpr_read_port
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W   = GprDataW,
  parameter int unsigned ADDR_W   = GprAddrW,
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  input  logic [DATA_W-1:0] reg_data_i,
  input  logic              reg_pending_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              rd_valid_o,
  output logic              rd_busy_o
);

  logic [DATA_W-1:0] data_d, data_q;
  logic              valid_d, valid_q;
  logic              busy_d, busy_q;
  logic              hit_zero;
  logic              hit_bypass;

  assign hit_zero   = is_zero_reg(ZERO_REG != 0, 32'(rd_addr_i));
  assign hit_bypass = (BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i);

  always_comb begin
    data_d  = data_q;
    busy_d  = busy_q;
    valid_d = rd_en_i;
    if (rd_en_i) begin
      // Zero register beats forwarding; forwarded data is never busy.
      if (hit_zero) begin
        data_d = '0;
        busy_d = 1'b0;
      end else if (hit_bypass) begin
        data_d = wr_data_i;
        busy_d = 1'b0;
      end else begin
        data_d = reg_data_i;
        busy_d = reg_pending_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign rd_data_o  = data_q;
  assign rd_valid_o = valid_q;
  assign rd_busy_o  = busy_q;

endmodule

// File: rtl/gpr_file.sv
// Parametrised register file: two registered read ports, one write port and a
// per-register pending scoreboard.
//   clk, rst : clock, async active-high reset
//   bus      : gpr_file_if slave (read ports A/B, write, reserve, pending vector)
module gpr_file
  import gpr_pkg::*;
#(
  parameter int unsigned DATA_W   = GprDataW,
  parameter int unsigned NUM_REGS = GprNumRegs,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
  parameter int unsigned ZERO_REG = 0,
  parameter int unsigned BYPASS   = 1
) (
  input logic       clk,
  input logic       rst,
  gpr_file_if.slave bus
);

  logic [DATA_W-1:0]   regs_d [NUM_REGS];
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_d, pending_q;
  logic                wr_ok;
  logic                rsv_ok;

  assign wr_ok  = bus.wr_en  && !is_zero_reg(ZERO_REG != 0, 32'(bus.wr_addr));
  assign rsv_ok = bus.rsv_en && !is_zero_reg(ZERO_REG != 0, 32'(bus.rsv_addr));

  always_comb begin
    regs_d    = regs_q;
    pending_d = pending_q;
    if (wr_ok) begin
      regs_d[bus.wr_addr]    = bus.wr_data;
      pending_d[bus.wr_addr] = 1'b0;
    end
    // Applied after the clear so a new reservation outlives a same-cycle write-back.
    if (rsv_ok) begin
      pending_d[bus.rsv_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q    <= '{default: '0};
      pending_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pending_q <= pending_d;
    end
  end

  assign bus.pending = pending_q;

  gpr_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_port_a (
    .clk          (clk),
    .rst          (rst),
    .rd_en_i      (bus.rd_en_a),
    .rd_addr_i    (bus.rd_addr_a),
    .reg_data_i   (regs_q[bus.rd_addr_a]),
    .reg_pending_i(pending_q[bus.rd_addr_a]),
    .wr_en_i      (bus.wr_en),
    .wr_addr_i    (bus.wr_addr),
    .wr_data_i    (bus.wr_data),
    .rd_data_o    (bus.rd_data_a),
    .rd_valid_o   (bus.rd_valid_a),
    .rd_busy_o    (bus.rd_busy_a)
  );

  gpr_read_port #(
    .DATA_W  (DATA_W),
    .ADDR_W  (ADDR_W),
    .ZERO_REG(ZERO_REG),
    .BYPASS  (BYPASS)
  ) u_port_b (
    .clk          (clk),
    .rst          (rst),
    .rd_en_i      (bus.rd_en_b),
    .rd_addr_i    (bus.rd_addr_b),
    .reg_data_i   (regs_q[bus.rd_addr_b]),
    .reg_pending_i(pending_q[bus.rd_addr_b]),
    .wr_en_i      (bus.wr_en),
    .wr_addr_i    (bus.wr_addr),
    .wr_data_i    (bus.wr_data),
    .rd_data_o    (bus.rd_data_b),
    .rd_valid_o   (bus.rd_valid_b),
    .rd_busy_o    (bus.rd_busy_b)
  );

endmodule

// File: doc/gpr_file.md
Name: gpr_file

Overview:
Parametrised general-purpose register file; next generation of the 8x8 single-port GPR block.
- Two independent registered read ports and one write port, all usable in the same cycle. The old block had one shared port with read priority over write.
- Optional hardwired zero register and write-to-read bypass.
- Per-register pending (scoreboard) bits so the datapath controller can detect reads of registers awaiting write-back.
- Sits between instruction decode (read/reserve requests) and ALU write-back.

Parameters:
- DATA_W, 8, register width in bits
- NUM_REGS, 8, number of registers (power of two, >=2)
- ADDR_W, $clog2(NUM_REGS), register index width (derived; do not override)
- ZERO_REG, 0, 1 = register 0 reads as 0 and ignores writes/reserves
- BYPASS, 1, 1 = same-cycle write data forwarded to a read of the same address

Ports:
- clk  in  1  system clock, all state on posedge
- rst  in  1  asynchronous active-high reset
- rd_en_a  in  1  read request, port A
- rd_addr_a  in  ADDR_W  read index, port A
- rd_data_a  out  DATA_W  registered read data, port A
- rd_valid_a  out  1  rd_data_a updated this cycle
- rd_busy_a  out  1  register read on port A was pending at sample time
- rd_en_b, rd_addr_b, rd_data_b, rd_valid_b, rd_busy_b  as port A, port B
- wr_en  in  1  write strobe
- wr_addr  in  ADDR_W  write index
- wr_data  in  DATA_W  write data
- rsv_en  in  1  mark register as awaiting write-back
- rsv_addr  in  ADDR_W  register to reserve
- pending  out  NUM_REGS  live scoreboard vector, bit i = register i pending

Behaviour:
- Reset (async assert, sync release):
  - all registers = 0, pending = 0
  - rd_data_a/b = 0, rd_valid_a/b = 0, rd_busy_a/b = 0
- Write: wr_en at edge N commits wr_data to reg[wr_addr] at edge N. ZERO_REG=1 and wr_addr=0: write dropped.
- Read latency is 1 cycle:
  - rd_en_x sampled at edge N -> rd_data_x, rd_valid_x=1 and rd_busy_x valid after edge N.
  - rd_en_x=0 -> rd_valid_x=0 next cycle; rd_data_x and rd_busy_x hold their last values.
- Read/write same address, same cycle:
  - BYPASS=1 -> rd_data returns wr_data, rd_busy=0.
  - BYPASS=0 -> rd_data returns the old value, rd_busy reflects the pre-edge pending bit.
- Both ports may read the same address; each behaves independently and identically.
- ZERO_REG=1 read of address 0 -> rd_data=0, rd_busy=0, regardless of bypass.
- Scoreboard:
  - rsv_en sets pending[rsv_addr] at the edge.
  - wr_en clears pending[wr_addr] at the edge.
  - rsv and wr to the same address in the same cycle -> pending stays set (new producer wins).
  - rsv of an already-pending register -> no change (no counting).
  - ZERO_REG=1: rsv_addr=0 is ignored.
- rd_busy_x = pending[rd_addr_x] sampled before the edge, except when bypassed as above. The read still returns the current (stale) value; no stall is generated internally.
- Address width is exact; there are no out-of-range indices.
- Reset asserted mid-operation clears everything immediately; in-flight reads produce no valid.

Decomposition:
- Package gpr_pkg:
  - default DATA_W / NUM_REGS constants
  - typedef gpr_addr_t, gpr_data_t
  - function for the zero-register check
- Sub-module gpr_read_port, instantiated twice. It contains the output registers, bypass mux, zero-register masking and busy sampling.
- Storage array and scoreboard stay in gpr_file.

Test Plan:
- Reset, then read all 8 registers on both ports -> rd_data=0x00, rd_valid=1, rd_busy=0 one cycle after each request.
- Write reg3=0xA5, then next cycle read A=3, B=3 -> both return 0xA5 one cycle later.
- Write reg5=0x3C and read A=5 in the same cycle:
  - BYPASS=1 -> 0x3C
  - BYPASS=0 -> previous 0x00, then a re-read gives 0x3C
- ZERO_REG=1: write reg0=0xFF, rsv 0, read A=0 -> rd_data=0x00, pending[0]=0.
- rsv 2 -> pending=0x04; read B=2 -> rd_busy_b=1; rsv 2 plus write reg2=0x11 in the same cycle -> pending[2] stays 1; a later write alone -> pending=0x00 and the read returns 0x11 with busy=0.
- Assert rst between issuing a read and its response -> rd_valid=0, registers and pending cleared, rd_data=0x00.
